frame_seq: RTL and testbench
============================

# frame_seq

Frame sequencer for the receiver DSP. It accepts a valid/ready sample stream and writes one frame of samples into data memory bank I. It then releases the DSP from reset to process the frame, and returns the DSP to reset when the DSP signals completion. It owns bank I's write port and the DSP's reset input, replacing the manual load-then-release sequence.

## Interface
- FRAME_LEN, 1024: samples per frame; legal range 2..2^ADDR_W.
- ADDR_W, 15: bank I address width (SRAM_ADDR_LEN).
- DATA_W, 16: sample/word width (REG_WORD_LEN).
- MAX_RUN, 65535: RUN-state watchdog limit in cycles; used only with the timeout feature.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- enable  in  1  permit a new frame; sampled only in IDLE and DONE.
- s_valid  in  1  sample available.
- s_data  in  DATA_W  sample word.
- s_ready  out  1  block accepts a sample this cycle.
- mem_write_en  out  1  bank I write strobe.
- mem_write_addr  out  ADDR_W  bank I write address.
- mem_write_data  out  DATA_W  bank I write data.
- dsp_rst  out  1  DSP reset, active-high.
- dsp_done  in  1  DSP frame-complete level.
- busy  out  1  state is not IDLE.
- frame_cnt  out  16  completed frames; wraps at 65535→0.
- timeout  out  1  sticky watchdog flag.

## Operation
- Reset values: state IDLE, s_ready 0, mem_write_en 0, mem_write_addr 0, mem_write_data 0, dsp_rst 1, busy 0, frame_cnt 0, timeout 0. Assertion mid-frame aborts immediately. The partial frame is discarded, and the DSP is held in reset by the asynchronous reset value.
- IDLE: when enable=1, go to FILL and clear the sample index.
- FILL: s_ready=1, decoded from the state register only.
  - Each cycle with s_valid & s_ready is a handshake; it writes s_data at address = index.
  - After the handshake for index FRAME_LEN-1, go to START. No more samples are accepted.
  - Cycles without s_valid: index holds and no write occurs.
- START: single cycle; dsp_rst stays 1 so the last write settles. Go to RUN.
- RUN: dsp_rst=0.
  - dsp_done=1 → DONE.
  - With the timeout feature, the run counter reaching MAX_RUN → DONE with timeout set.
  - If dsp_done and the watchdog limit occur in the same cycle, dsp_done wins: no timeout, and frame_cnt increments.
- DONE: single cycle; dsp_rst=1.
  - frame_cnt increments only on a dsp_done exit.
  - enable=1 → FILL with index 0; otherwise → IDLE.
- enable changes during FILL, START or RUN have no effect.
- timeout clears only on reset.

## Timing
- Write latency: a handshake in cycle t drives mem_write_en=1 with that address and data in cycle t+1, registered, for exactly one cycle.
- FRAME_LEN back-to-back samples take FRAME_LEN cycles of FILL.
- dsp_rst falls exactly 2 cycles after the final handshake (FILL→START→RUN).
- dsp_done is sampled synchronously. dsp_rst rises in the cycle after dsp_done is first seen high.
- Minimum frame-to-frame gap with enable held high: 1 cycle (DONE) before s_ready reasserts.

## Configuration
- FRAME_SEQ_TIMEOUT_EN defined:
  - RUN-cycle counter, cleared on RUN entry, is included.
  - After MAX_RUN cycles in RUN without dsp_done: force DONE and set timeout.
- Not defined:
  - Counter logic is absent and timeout is tied to 0.
  - RUN waits for dsp_done indefinitely.

## Structure
- State encodings FSEQ_IDLE/FILL/START/RUN/DONE go in the shared definitions header, with 3-bit binary encodings.
- Bus widths reuse the existing SRAM_ADDR_LEN and REG_WORD_LEN definitions.
- The FSM, index counter and registered write port are a single module.
- One natural sub-module: frame_seq_wdog, the watchdog counter, instantiated only under FRAME_SEQ_TIMEOUT_EN.

## Test plan
- FRAME_LEN=4, enable=1, s_valid=1 continuously, data 25,26,27,28 → bank I addresses 0..3 hold 25..28, dsp_rst falls 2 cycles after the 4th handshake.
- Same run, dsp_done pulsed high after 10 RUN cycles → dsp_rst rises the next cycle, frame_cnt=1, s_ready reasserts 1 cycle later.
- s_valid toggling 1,0,0,1,1,0,1 → exactly 4 writes to consecutive addresses 0..3; no write strobe in idle-input cycles.
- rst asserted low during RUN of frame 2 → all outputs at reset values immediately, frame_cnt=0, dsp_rst=1.
- With FRAME_SEQ_TIMEOUT_EN, MAX_RUN=8, dsp_done never asserted → DONE after 8 RUN cycles, timeout=1, frame_cnt unchanged; dsp_done coinciding with cycle 8 → timeout stays 0.
- enable=0 while in DONE → IDLE, busy=0, s_ready stays 0 despite s_valid=1.

Source files
------------

// File: rtl/frame_seq_pkg.sv
// Shared definitions for the frame sequencer: bus widths, state encodings and
// a counter-sizing helper.
package frame_seq_pkg;

  localparam int SRAM_ADDR_LEN = 15;
  localparam int REG_WORD_LEN  = 16;
  localparam int FRAME_CNT_W   = 16;

  typedef enum logic [2:0] {
    FSEQ_IDLE  = 3'd0,
    FSEQ_FILL  = 3'd1,
    FSEQ_START = 3'd2,
    FSEQ_RUN   = 3'd3,
    FSEQ_DONE  = 3'd4
  } fseq_state_e;

  // Bits needed to hold every value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/frame_seq_wdog.sv
// RUN-state watchdog: counts consecutive RUN cycles and flags the MAX_RUN-th
// one. Only instantiated when FRAME_SEQ_TIMEOUT_EN is defined.
module frame_seq_wdog
  import frame_seq_pkg::*;
#(
  parameter int MAX_RUN = 65535
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic expired
);

  localparam int CW = cnt_width(MAX_RUN);
  localparam logic [CW-1:0] LIMIT = CW'(MAX_RUN - 1);

  logic [CW-1:0] count;

  // Any cycle outside RUN clears the count, so every RUN entry starts from 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!run) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + 1'b1;
    end
  end

  assign expired = run && (count == LIMIT);

endmodule

// File: rtl/frame_seq.sv
// Frame sequencer: loads one frame into bank I, then runs the DSP until it
// reports completion. Optional RUN watchdog under FRAME_SEQ_TIMEOUT_EN.
//
// Sample stream: a transfer happens on every rising edge where s_valid and
// s_ready are both high; s_ready depends only on the state register, and
// s_valid may drop without a transfer.
module frame_seq
  import frame_seq_pkg::*;
#(
  parameter int FRAME_LEN = 1024,
  parameter int ADDR_W    = SRAM_ADDR_LEN,
  parameter int DATA_W    = REG_WORD_LEN,
  parameter int MAX_RUN   = 65535
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   s_valid,
  input  logic [DATA_W-1:0]      s_data,
  output logic                   s_ready,
  output logic                   mem_write_en,
  output logic [ADDR_W-1:0]      mem_write_addr,
  output logic [DATA_W-1:0]      mem_write_data,
  output logic                   dsp_rst,
  input  logic                   dsp_done,
  output logic                   busy,
  output logic [FRAME_CNT_W-1:0] frame_cnt,
  output logic                   timeout,
  output fseq_state_e            fsm_state
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  if ((FRAME_LEN < 2) || (longint'(FRAME_LEN) > (longint'(1) << ADDR_W)) || (MAX_RUN < 1))
  begin : g_param_check
    $error("frame_seq: FRAME_LEN must be 2..2**ADDR_W and MAX_RUN at least 1");
  end

  fseq_state_e       state;
  fseq_state_e       state_next;
  logic [ADDR_W-1:0] index;
  logic              handshake;
  logic              frame_done;
  logic              wdog_expired;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FSEQ_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // dsp_done has priority over the watchdog when both land in the same cycle.
  always_comb begin
    state_next = state;
    handshake  = 1'b0;
    frame_done = 1'b0;
    case (state)
      FSEQ_IDLE: begin
        if (enable) state_next = FSEQ_FILL;
      end
      FSEQ_FILL: begin
        if (s_valid) begin
          handshake = 1'b1;
          if (index == LAST_IDX) state_next = FSEQ_START;
        end
      end
      FSEQ_START: begin
        state_next = FSEQ_RUN;
      end
      FSEQ_RUN: begin
        if (dsp_done) begin
          state_next = FSEQ_DONE;
          frame_done = 1'b1;
        end else if (wdog_expired) begin
          state_next = FSEQ_DONE;
        end
      end
      FSEQ_DONE: begin
        state_next = enable ? FSEQ_FILL : FSEQ_IDLE;
      end
      default: begin
        state_next = FSEQ_IDLE;
      end
    endcase
  end

  assign s_ready   = (state == FSEQ_FILL);
  assign busy      = (state != FSEQ_IDLE);
  assign dsp_rst   = (state != FSEQ_RUN);
  assign fsm_state = state;

  // Index is parked at 0 outside FILL, so every FILL entry starts a new frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      index <= '0;
    end else if (state != FSEQ_FILL) begin
      index <= '0;
    end else if (handshake) begin
      index <= index + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_write_en   <= 1'b0;
      mem_write_addr <= '0;
      mem_write_data <= '0;
    end else begin
      mem_write_en <= handshake;
      if (handshake) begin
        mem_write_addr <= index;
        mem_write_data <= s_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      frame_cnt <= '0;
    end else if (frame_done) begin
      frame_cnt <= frame_cnt + 1'b1;
    end
  end

`ifdef FRAME_SEQ_TIMEOUT_EN
  frame_seq_wdog #(
    .MAX_RUN (MAX_RUN)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .run     (state == FSEQ_RUN),
    .expired (wdog_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timeout <= 1'b0;
    end else if ((state == FSEQ_RUN) && !dsp_done && wdog_expired) begin
      timeout <= 1'b1;
    end
  end
`else
  assign wdog_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_frame_seq.sv
// Self-checking bench for frame_seq: directed scenarios with literal
// expectations, then randomized traffic checked against a behavioural model.
`timescale 1ns/1ps
module tb_frame_seq;
  import frame_seq_pkg::*;

  localparam int FL      = 4;
  localparam int AW      = 15;
  localparam int DW      = 16;
  localparam int MAX_RUN = 8;
`ifdef FRAME_SEQ_TIMEOUT_EN
  localparam bit TMO_EN     = 1'b1;
  localparam int DONE_AFTER = 5;
`else
  localparam bit TMO_EN     = 1'b0;
  localparam int DONE_AFTER = 10;
`endif

  // Model phases (the bench's own names for the frame life cycle).
  localparam int M_IDLE = 0, M_LOAD = 1, M_SETTLE = 2, M_RUN = 3, M_DONE = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          enable = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          dsp_done = 1'b0;
  logic          s_ready;
  logic          mem_write_en;
  logic [AW-1:0] mem_write_addr;
  logic [DW-1:0] mem_write_data;
  logic          dsp_rst;
  logic          busy;
  logic [15:0]   frame_cnt;
  logic          timeout;
  fseq_state_e   fsm_state;

  int tests_run = 0;
  int tests_failed = 0;

  // Behavioural model state
  int                 m_ph = M_IDLE;
  int                 m_idx = 0;
  int                 m_run = 0;
  logic [15:0]        m_fcnt = '0;
  logic               m_tmo = 1'b0;
  logic [AW+DW-1:0]   exp_q[$];
  int                 wr_total = 0;
  logic [DW-1:0]      mem_img[FL];
  int                 addr_log[$];

  frame_seq #(
    .FRAME_LEN (FL),
    .ADDR_W    (AW),
    .DATA_W    (DW),
    .MAX_RUN   (MAX_RUN)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .s_valid        (s_valid),
    .s_data         (s_data),
    .s_ready        (s_ready),
    .mem_write_en   (mem_write_en),
    .mem_write_addr (mem_write_addr),
    .mem_write_data (mem_write_data),
    .dsp_rst        (dsp_rst),
    .dsp_done       (dsp_done),
    .busy           (busy),
    .frame_cnt      (frame_cnt),
    .timeout        (timeout),
    .fsm_state      (fsm_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: advances one cycle from the inputs seen at each rising edge.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_ph = M_IDLE; m_idx = 0; m_run = 0; m_fcnt = '0; m_tmo = 1'b0;
      exp_q.delete();
    end else begin
      case (m_ph)
        M_IDLE: if (enable) begin m_ph = M_LOAD; m_idx = 0; end
        M_LOAD: if (s_valid) begin
          exp_q.push_back({AW'(m_idx), s_data});
          if (m_idx == FL - 1) m_ph = M_SETTLE;
          else m_idx++;
        end
        M_SETTLE: begin m_ph = M_RUN; m_run = 0; end
        M_RUN: begin
          m_run++;
          if (dsp_done) begin m_ph = M_DONE; m_fcnt++; end
          else if (TMO_EN && m_run == MAX_RUN) begin m_ph = M_DONE; m_tmo = 1'b1; end
        end
        M_DONE: begin m_ph = enable ? M_LOAD : M_IDLE; m_idx = 0; end
        default: m_ph = M_IDLE;
      endcase
    end
  end

  // Compare process: every cycle out of reset, just after the edge.
  always @(posedge clk) begin
    logic [AW+DW-1:0] e;
    #1;
    if (rst) begin
      check("s_ready", s_ready, m_ph == M_LOAD);
      check("busy", busy, m_ph != M_IDLE);
      check("dsp_rst", dsp_rst, m_ph != M_RUN);
      check("frame_cnt", frame_cnt, m_fcnt);
      check("timeout", timeout, m_tmo);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("wr_en", mem_write_en, 1);
        check("wr_addr", mem_write_addr, e[AW+DW-1:DW]);
        check("wr_data", mem_write_data, e[DW-1:0]);
      end else begin
        check("wr_en_idle", mem_write_en, 0);
      end
      if (mem_write_en) begin
        wr_total++;
        addr_log.push_back(int'(mem_write_addr));
        if (mem_write_addr < FL) mem_img[mem_write_addr] = mem_write_data;
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after the n-th transfer.
  task automatic feed(input int n, input logic [31:0] pat, input int plen,
                      input logic [DW-1:0] base, output int cycles);
    int sent = 0;
    logic hs;
    cycles = 0;
    while (sent < n && cycles < 64) begin
      s_valid = (plen == 0) ? 1'b1 : pat[cycles % plen];
      s_data  = base + DW'(sent);
      hs = s_valid && s_ready;
      @(negedge clk);
      cycles++;
      if (hs) sent++;
    end
    s_valid = 1'b0;
    check("feed_count", sent, n);
  endtask

  task automatic reset_outputs_check(input string tag);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_wr_en"}, mem_write_en, 0);
    check({tag, "_wr_addr"}, mem_write_addr, 0);
    check({tag, "_wr_data"}, mem_write_data, 0);
    check({tag, "_dsp_rst"}, dsp_rst, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_frame_cnt"}, frame_cnt, 0);
    check({tag, "_timeout"}, timeout, 0);
    check({tag, "_state"}, fsm_state, FSEQ_IDLE);
  endtask

  initial begin
    int cyc;
    int n;
    logic [15:0] fc_before;

    repeat (3) @(negedge clk);
    reset_outputs_check("por");
    rst = 1'b1;

    // Frame 1: continuous samples 25..28
    @(negedge clk); enable = 1'b1;
    @(negedge clk); check("fill_ready", s_ready, 1);
    feed(FL, 32'h0, 0, 16'd25, cyc);
    check("fill_cycles", cyc, FL);
    check("start_rst_held", dsp_rst, 1);
    check("start_no_ready", s_ready, 0);
    @(negedge clk);
    check("rst_fall_2cyc", dsp_rst, 0);
    for (int i = 0; i < FL; i++) check("mem_f1", mem_img[i], 25 + i);
    for (int i = 1; i < DONE_AFTER; i++) @(negedge clk);
    check("run_hold", dsp_rst, 0);
    dsp_done = 1'b1;
    @(negedge clk); dsp_done = 1'b0;
    check("done_rst_rise", dsp_rst, 1);
    check("done_frame_cnt", frame_cnt, 1);
    check("done_no_ready", s_ready, 0);
    @(negedge clk);
    check("refill_ready", s_ready, 1);

    // Frame 2: gappy valid 1,0,0,1,1,0,1
    addr_log.delete();
    n = wr_total;
    feed(FL, 32'b1011001, 7, 16'd100, cyc);
    check("gappy_cycles", cyc, 7);
    check("gappy_writes", wr_total - n, 4);
    check("gappy_log_size", addr_log.size(), 4);
    for (int i = 0; i < FL; i++) begin
      if (i < addr_log.size()) check("gappy_addr", addr_log[i], i);
      check("mem_f2", mem_img[i], 100 + i);
    end

    // Abort frame 2 in RUN with reset
    @(negedge clk);
    check("f2_run", dsp_rst, 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1 reset_outputs_check("abort");
    @(negedge clk); rst = 1'b1;

    // enable dropped in START, frame ends in DONE -> IDLE
    @(negedge clk);
    feed(FL, 32'h0, 0, 16'd500, cyc);
    enable = 1'b0;
    @(negedge clk);
    check("f3_run", dsp_rst, 0);
    dsp_done = 1'b1;
    @(negedge clk); dsp_done = 1'b0; s_valid = 1'b1;
    check("f3_done_cnt", frame_cnt, 1);
    @(negedge clk);
    n = wr_total;
    for (int i = 0; i < 3; i++) begin
      check("idle_busy", busy, 0);
      check("idle_no_ready", s_ready, 0);
      @(negedge clk);
    end
    check("idle_no_writes", wr_total - n, 0);
    s_valid = 1'b0;

    // Watchdog behaviour
    fc_before = frame_cnt;
    enable = 1'b1;
    @(negedge clk);
    feed(FL, 32'h0, 0, 16'd700, cyc);
    enable = 1'b0;
    @(negedge clk);
`ifdef FRAME_SEQ_TIMEOUT_EN
    n = 1;
    while (dsp_rst == 1'b0 && n < 50) begin
      @(negedge clk);
      if (dsp_rst == 1'b0) n++;
    end
    check("wdog_run_cycles", n, MAX_RUN);
    check("wdog_timeout", timeout, 1);
    check("wdog_frame_cnt", frame_cnt, fc_before);
    #2 rst = 1'b0;
    @(negedge clk); rst = 1'b1; enable = 1'b1;
    @(negedge clk);
    feed(FL, 32'h0, 0, 16'd900, cyc);
    enable = 1'b0;
    @(negedge clk);
    for (int i = 1; i < MAX_RUN; i++) @(negedge clk);
    dsp_done = 1'b1;
    @(negedge clk); dsp_done = 1'b0;
    check("tie_timeout", timeout, 0);
    check("tie_frame_cnt", frame_cnt, 1);
`else
    repeat (3 * MAX_RUN) @(negedge clk);
    check("nowdog_still_run", dsp_rst, 0);
    check("nowdog_timeout", timeout, 0);
    dsp_done = 1'b1;
    @(negedge clk); dsp_done = 1'b0;
    check("nowdog_frame_cnt", frame_cnt, fc_before + 16'd1);
`endif
    @(negedge clk);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      enable   = ($urandom_range(0, 3) != 0);
      s_valid  = $urandom_range(0, 1);
      s_data   = DW'($urandom);
      dsp_done = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #3 rst = 1'b0;
        #1 check("rand_rst_busy", busy, 0);
        @(negedge clk); rst = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    enable = 1'b0; s_valid = 1'b0; dsp_done = 1'b0;
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

endmodule
